// File: rtl/step_pulse_gen.sv
// step_pulse_gen
//   Step-pulse generator for the pedometer datapath. It emits evenly spaced
//   single-cycle step pulses at a per-second rate. The rate comes either from
//   a fixed mode (walk/jog/run) or from a programmable multi-segment profile
//   (hybrid). A phase accumulator gives exact rates without derived clocks.
//   The block also counts steps and elapsed seconds, and stretches each pulse
//   for an LED.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-low reset
//   start        run enable; low = idle and clear
//   mode         00 walk, 01 jog, 10 run, 11 hybrid profile
//   prof_we      profile table write strobe
//   prof_addr    profile table index
//   prof_rate    segment rate, pulses per second
//   prof_dur     segment duration in seconds; 0 marks end of profile
//   step_pulse   one-cycle pulse per step
//   light_out    step_pulse stretched to LED_CYC cycles
//   step_count   steps since start rose, saturating
//   sec_count    whole seconds since start rose, saturating
//   cur_rate     rate currently applied
//   profile_done hybrid profile exhausted
//   cnt_sat      a step arrived while step_count was already all-ones
//
// State table
//   state     | meaning
//   S_IDLE    | waiting for start; all run state held clear
//   S_FIXED   | running at a constant mode rate
//   S_PROFILE | running through profile segments
//   S_DONE    | profile exhausted; rate 0; counts frozen
module step_pulse_gen #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int RATE_W     = 8,
   parameter int CNT_W      = 16,
   parameter int SEC_W      = 9,
   parameter int PROF_DEPTH = 16,
   parameter int WALK_RATE  = 32,
   parameter int JOG_RATE   = 64,
   parameter int RUN_RATE   = 128,
   parameter int LED_CYC    = CLK_HZ / 100
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [1:0]                    mode,
   input  logic                          prof_we,
   input  logic [$clog2(PROF_DEPTH)-1:0] prof_addr,
   input  logic [RATE_W-1:0]             prof_rate,
   input  logic [SEC_W-1:0]              prof_dur,
   output logic                          step_pulse,
   output logic                          light_out,
   output logic [CNT_W-1:0]              step_count,
   output logic [SEC_W-1:0]              sec_count,
   output logic [RATE_W-1:0]             cur_rate,
   output logic                          profile_done,
   output logic                          cnt_sat
);

   localparam int IDX_W  = $clog2(PROF_DEPTH);
   localparam int SIDX_W = IDX_W + 1;
   localparam int ACC_W  = $clog2(CLK_HZ + 2**RATE_W);
   localparam int DIV_W  = $clog2(CLK_HZ);
   localparam int LED_W  = $clog2(LED_CYC + 1);

   localparam logic [ACC_W-1:0]  CLK_HZ_A  = ACC_W'(CLK_HZ);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_HZ - 1);
   localparam logic [LED_W-1:0]  LED_LOAD  = LED_W'(LED_CYC);
   localparam logic [SIDX_W-1:0] DEPTH_S   = SIDX_W'(PROF_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FIXED   = 2'd1,
      S_PROFILE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t state, state_nx;

   logic [RATE_W-1:0] tab_rate [PROF_DEPTH];
   logic [SEC_W-1:0]  tab_dur  [PROF_DEPTH];

   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  sum;
   logic              wrap;
   logic [DIV_W-1:0]  div;
   logic              sec_tick;
   logic [SEC_W-1:0]  seg_left;
   logic [SIDX_W-1:0] seg_idx;
   logic [SIDX_W-1:0] ld_idx;
   logic [RATE_W-1:0] ld_rate;
   logic [SEC_W-1:0]  ld_dur;
   logic [RATE_W-1:0] fixed_rate;
   logic [LED_W-1:0]  led_cnt;
   logic              run_en;
   logic              prof_act;
   logic              done_o;

   // Profile table: writable at any time; run logic only ever reads it at a
   // segment load, so the segment currently in use never changes underneath.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < PROF_DEPTH; i++) begin
            tab_rate[i] <= '0;
            tab_dur[i]  <= '0;
         end
      end else if (prof_we) begin
         tab_rate[prof_addr] <= prof_rate;
         tab_dur[prof_addr]  <= prof_dur;
      end
   end

   // Segment fetch. An index past the table, or a zero duration, reads back
   // as an end marker with rate 0. This keeps the accumulator phase unchanged
   // for the single cycle before DONE.
   always_comb begin
      ld_idx  = (state == S_IDLE) ? '0 : seg_idx;
      ld_rate = '0;
      ld_dur  = '0;
      if (ld_idx < DEPTH_S) begin
         ld_dur = tab_dur[ld_idx[IDX_W-1:0]];
         if (ld_dur != '0) begin
            ld_rate = tab_rate[ld_idx[IDX_W-1:0]];
         end
      end
   end

   always_comb begin
      case (mode)
         2'b00:   fixed_rate = RATE_W'(WALK_RATE);
         2'b01:   fixed_rate = RATE_W'(JOG_RATE);
         2'b10:   fixed_rate = RATE_W'(RUN_RATE);
         default: fixed_rate = '0;
      endcase
   end

   // FSM: state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // FSM: next state
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = (mode == 2'b11) ? S_PROFILE : S_FIXED;
            end
         end
         S_FIXED:   state_nx = S_FIXED;
         S_PROFILE: begin
            // seg_left reaches 0 only when an end marker was captured.
            if (seg_left == '0) begin
               state_nx = S_DONE;
            end
         end
         S_DONE:    state_nx = S_DONE;
         default:   state_nx = S_IDLE;
      endcase
      if (!start) begin
         state_nx = S_IDLE;
      end
   end

   // FSM: outputs
   always_comb begin
      run_en   = 1'b0;
      prof_act = 1'b0;
      done_o   = 1'b0;
      case (state)
         S_FIXED:   run_en = 1'b1;
         S_PROFILE: begin
            run_en   = 1'b1;
            prof_act = 1'b1;
         end
         S_DONE:    done_o = 1'b1;
         default:   ;
      endcase
   end

   assign profile_done = done_o;
   assign light_out    = (led_cnt != '0);

   assign sum      = acc + ACC_W'(cur_rate);
   assign wrap     = (sum >= CLK_HZ_A);
   assign sec_tick = run_en && (div == DIV_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc        <= '0;
         div        <= '0;
         seg_left   <= '0;
         seg_idx    <= '0;
         led_cnt    <= '0;
         step_pulse <= 1'b0;
         step_count <= '0;
         sec_count  <= '0;
         cur_rate   <= '0;
         cnt_sat    <= 1'b0;
      end else if (!start) begin
         acc        <= '0;
         div        <= '0;
         seg_left   <= '0;
         seg_idx    <= '0;
         led_cnt    <= '0;
         step_pulse <= 1'b0;
         step_count <= '0;
         sec_count  <= '0;
         cur_rate   <= '0;
         cnt_sat    <= 1'b0;
      end else begin
         step_pulse <= 1'b0;

         // Entry: mode is sampled only here, so later mode changes are ignored.
         if (state == S_IDLE) begin
            if (mode == 2'b11) begin
               cur_rate <= ld_rate;
               seg_left <= ld_dur;
               seg_idx  <= ld_idx + 1'b1;
            end else begin
               cur_rate <= fixed_rate;
            end
         end

         if (run_en) begin
            div <= sec_tick ? '0 : div + 1'b1;
            if (sec_tick && (sec_count != '1)) begin
               sec_count <= sec_count + 1'b1;
            end
            if (wrap) begin
               acc        <= sum - CLK_HZ_A;
               step_pulse <= 1'b1;
               // cnt_sat flags the first step that could not be counted.
               if (step_count == '1) begin
                  cnt_sat <= 1'b1;
               end else begin
                  step_count <= step_count + 1'b1;
               end
            end else begin
               acc <= sum;
            end
         end

         // The tick that drains a segment loads the next one on the same edge.
         // acc is left alone, so the new rate continues the existing phase.
         if (prof_act && sec_tick && (seg_left != '0)) begin
            if (seg_left == SEC_W'(1)) begin
               cur_rate <= ld_rate;
               seg_left <= ld_dur;
               seg_idx  <= ld_idx + 1'b1;
            end else begin
               seg_left <= seg_left - 1'b1;
            end
         end

         if (state == S_DONE) begin
            cur_rate <= '0;
         end

         if (step_pulse) begin
            led_cnt <= LED_LOAD;
         end else if (led_cnt != '0) begin
            led_cnt <= led_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_step_pulse_gen.sv
module tb_step_pulse_gen;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  mode;
   logic        prof_we;
   logic [3:0]  prof_addr;
   logic [7:0]  prof_rate;
   logic [8:0]  prof_dur;

   logic        step_pulse, light_out, profile_done, cnt_sat;
   logic [15:0] step_count;
   logic [8:0]  sec_count;
   logic [7:0]  cur_rate;

   logic        s_step_pulse, s_light_out, s_profile_done, s_cnt_sat;
   logic [3:0]  s_step_count;
   logic [8:0]  s_sec_count;
   logic [7:0]  s_cur_rate;

   int checks = 0;
   int errors = 0;

   step_pulse_gen #(.CLK_HZ(1000), .LED_CYC(4)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .prof_we(prof_we), .prof_addr(prof_addr), .prof_rate(prof_rate),
      .prof_dur(prof_dur), .step_pulse(step_pulse), .light_out(light_out),
      .step_count(step_count), .sec_count(sec_count), .cur_rate(cur_rate),
      .profile_done(profile_done), .cnt_sat(cnt_sat)
   );

   step_pulse_gen #(.CLK_HZ(1000), .LED_CYC(4), .CNT_W(4)) dut_s (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .prof_we(prof_we), .prof_addr(prof_addr), .prof_rate(prof_rate),
      .prof_dur(prof_dur), .step_pulse(s_step_pulse), .light_out(s_light_out),
      .step_count(s_step_count), .sec_count(s_sec_count), .cur_rate(s_cur_rate),
      .profile_done(s_profile_done), .cnt_sat(s_cnt_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic write_seg(input logic [3:0] a, input logic [7:0] r, input logic [8:0] d);
      prof_we = 1'b1; prof_addr = a; prof_rate = r; prof_dur = d;
      @(posedge clk); #1;
      prof_we = 1'b0;
   endtask

   task automatic begin_run(input logic [1:0] m);
      mode = m; start = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic stop_run();
      start = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({step_pulse, light_out, step_count, sec_count, cur_rate, profile_done, cnt_sat} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got sp=%0b lo=%0b sc=%0d sec=%0d rate=%0d pd=%0b sat=%0b want all 0",
                  step_pulse, light_out, step_count, sec_count, cur_rate, profile_done, cnt_sat);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_walk();
      int first_k = 0, last_k = 0, bad_sp = 0, npulse = 0;
      begin_run(2'b00);
      checks++;
      if (cur_rate !== 8'd32) begin errors++; $display("FAIL walk_rate got %0d want 32", cur_rate); end
      for (int k = 1; k <= 3000; k++) begin
         @(posedge clk); #1;
         if (step_pulse) begin
            npulse++;
            if (first_k == 0) first_k = k;
            else if ((k - last_k) != 31 && (k - last_k) != 32) bad_sp++;
            last_k = k;
         end
         if (k == 999) begin
            checks++;
            if (sec_count !== 9'd0) begin errors++; $display("FAIL walk_sec_999 got %0d want 0", sec_count); end
         end
         if (k == 1000) begin
            checks++;
            if (sec_count !== 9'd1) begin errors++; $display("FAIL walk_sec_1000 got %0d want 1", sec_count); end
         end
      end
      checks++;
      if (first_k != 32) begin errors++; $display("FAIL walk_first got %0d want 32", first_k); end
      checks++;
      if (bad_sp != 0) begin errors++; $display("FAIL walk_spacing got %0d bad want 0", bad_sp); end
      checks++;
      if (npulse != 96) begin errors++; $display("FAIL walk_npulse got %0d want 96", npulse); end
      checks++;
      if (step_count !== 16'd96) begin errors++; $display("FAIL walk_count got %0d want 96", step_count); end
      checks++;
      if (sec_count !== 9'd3) begin errors++; $display("FAIL walk_sec got %0d want 3", sec_count); end
      stop_run();
      checks++;
      if ({step_count, sec_count, cur_rate, light_out} !== '0) begin
         errors++;
         $display("FAIL walk_stop_clear got sc=%0d sec=%0d rate=%0d lo=%0b want 0", step_count, sec_count, cur_rate, light_out);
      end
   endtask

   task automatic test_back_to_back();
      begin_run(2'b00);
      repeat (100) @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({step_count, sec_count, cur_rate} !== '0) begin
         errors++;
         $display("FAIL b2b_clear got sc=%0d sec=%0d rate=%0d want 0", step_count, sec_count, cur_rate);
      end
      begin_run(2'b00);
      repeat (31) @(posedge clk);
      #1;
      checks++;
      if (step_count !== 16'd0) begin errors++; $display("FAIL b2b_early got %0d want 0", step_count); end
      @(posedge clk); #1;
      checks++;
      if (step_count !== 16'd1 || step_pulse !== 1'b1) begin
         errors++; $display("FAIL b2b_first got sc=%0d sp=%0b want 1 1", step_count, step_pulse);
      end
      stop_run();
   endtask

   task automatic test_saturate();
      begin_run(2'b10);
      repeat (124) @(posedge clk);
      #1;
      checks++;
      if (s_step_count !== 4'd15 || s_cnt_sat !== 1'b0) begin
         errors++; $display("FAIL sat_124 got sc=%0d sat=%0b want 15 0", s_step_count, s_cnt_sat);
      end
      @(posedge clk); #1;
      checks++;
      if (s_step_count !== 4'd15 || s_cnt_sat !== 1'b1) begin
         errors++; $display("FAIL sat_125 got sc=%0d sat=%0b want 15 1", s_step_count, s_cnt_sat);
      end
      checks++;
      if (step_count !== 16'd16) begin errors++; $display("FAIL sat_wide got %0d want 16", step_count); end
      stop_run();
      checks++;
      if (s_step_count !== 4'd0 || s_cnt_sat !== 1'b0) begin
         errors++; $display("FAIL sat_clear got sc=%0d sat=%0b want 0 0", s_step_count, s_cnt_sat);
      end
   endtask

   task automatic test_reset_midrun();
      begin_run(2'b10);
      repeat (9) @(posedge clk);
      #1;
      checks++;
      if (light_out !== 1'b1 || step_count !== 16'd1) begin
         errors++; $display("FAIL rst_pre got lo=%0b sc=%0d want 1 1", light_out, step_count);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({step_pulse, light_out, step_count, sec_count, cur_rate, profile_done, cnt_sat} !== '0) begin
         errors++;
         $display("FAIL rst_async got sp=%0b lo=%0b sc=%0d rate=%0d want 0", step_pulse, light_out, step_count, cur_rate);
      end
      @(posedge clk); #1;
      mode = 2'b00;
      reset = 1'b1;
      @(posedge clk); #1;
      repeat (31) @(posedge clk);
      #1;
      checks++;
      if (step_count !== 16'd0) begin errors++; $display("FAIL rst_fresh_early got %0d want 0", step_count); end
      @(posedge clk); #1;
      checks++;
      if (step_count !== 16'd1 || cur_rate !== 8'd32) begin
         errors++; $display("FAIL rst_fresh got sc=%0d rate=%0d want 1 32", step_count, cur_rate);
      end
      stop_run();
   endtask

   task automatic test_mode_ignore();
      begin_run(2'b00);
      repeat (500) @(posedge clk);
      #1;
      mode = 2'b10;
      repeat (500) @(posedge clk);
      #1;
      checks++;
      if (step_count !== 16'd32 || cur_rate !== 8'd32) begin
         errors++; $display("FAIL mode_ignore got sc=%0d rate=%0d want 32 32", step_count, cur_rate);
      end
      stop_run();
      write_seg(4'd0, 8'd10, 9'd2);
      write_seg(4'd1, 8'd50, 9'd1);
      write_seg(4'd2, 8'd77, 9'd0);
      begin_run(2'b11);
      repeat (100) @(posedge clk);
      #1;
      write_seg(4'd0, 8'd200, 9'd5);
      checks++;
      if (cur_rate !== 8'd10) begin errors++; $display("FAIL active_write got %0d want 10", cur_rate); end
      repeat (899) @(posedge clk);
      #1;
      checks++;
      if (step_count !== 16'd10) begin errors++; $display("FAIL active_count got %0d want 10", step_count); end
      stop_run();
   endtask

   task automatic test_profile();
      int late = 0;
      write_seg(4'd0, 8'd10, 9'd2);
      write_seg(4'd1, 8'd50, 9'd1);
      write_seg(4'd2, 8'd77, 9'd0);
      begin_run(2'b11);
      checks++;
      if (cur_rate !== 8'd10) begin errors++; $display("FAIL prof_rate0 got %0d want 10", cur_rate); end
      for (int k = 1; k <= 4000; k++) begin
         @(posedge clk); #1;
         if (k > 3000 && step_pulse) late++;
         if (k == 2000) begin
            checks++;
            if (step_count !== 16'd20 || cur_rate !== 8'd50) begin
               errors++; $display("FAIL prof_2000 got sc=%0d rate=%0d want 20 50", step_count, cur_rate);
            end
         end
         if (k == 3000) begin
            checks++;
            if (step_count !== 16'd70 || profile_done !== 1'b0) begin
               errors++; $display("FAIL prof_3000 got sc=%0d pd=%0b want 70 0", step_count, profile_done);
            end
         end
         if (k == 3001) begin
            checks++;
            if (profile_done !== 1'b1) begin errors++; $display("FAIL prof_done got %0b want 1", profile_done); end
         end
      end
      checks++;
      if (late != 0) begin errors++; $display("FAIL prof_late got %0d pulses want 0", late); end
      checks++;
      if (step_count !== 16'd70 || cur_rate !== 8'd0 || sec_count !== 9'd3 || profile_done !== 1'b1) begin
         errors++;
         $display("FAIL prof_end got sc=%0d rate=%0d sec=%0d pd=%0b want 70 0 3 1", step_count, cur_rate, sec_count, profile_done);
      end
      stop_run();
      checks++;
      if (profile_done !== 1'b0) begin errors++; $display("FAIL prof_clear got %0b want 0", profile_done); end
   endtask

   task automatic test_zero_profile();
      int npulse = 0;
      write_seg(4'd0, 8'd99, 9'd0);
      begin_run(2'b11);
      checks++;
      if (profile_done !== 1'b0 || cur_rate !== 8'd0) begin
         errors++; $display("FAIL zero_entry got pd=%0b rate=%0d want 0 0", profile_done, cur_rate);
      end
      @(posedge clk); #1;
      checks++;
      if (profile_done !== 1'b1) begin errors++; $display("FAIL zero_done got %0b want 1", profile_done); end
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (step_pulse) npulse++;
      end
      checks++;
      if (npulse != 0 || step_count !== 16'd0) begin
         errors++; $display("FAIL zero_pulses got n=%0d sc=%0d want 0 0", npulse, step_count);
      end
      stop_run();
   endtask

   task automatic test_fast();
      int first_k = 0, dark = 0;
      write_seg(4'd0, 8'd255, 9'd1);
      write_seg(4'd1, 8'd0, 9'd0);
      begin_run(2'b11);
      for (int k = 1; k <= 1000; k++) begin
         @(posedge clk); #1;
         if (step_pulse && first_k == 0) first_k = k;
         if (k >= 5 && light_out !== 1'b1) dark++;
      end
      checks++;
      if (first_k != 4) begin errors++; $display("FAIL fast_first got %0d want 4", first_k); end
      checks++;
      if (step_count !== 16'd255) begin errors++; $display("FAIL fast_count got %0d want 255", step_count); end
      checks++;
      if (dark != 0) begin errors++; $display("FAIL fast_light got %0d dark cycles want 0", dark); end
      stop_run();
      checks++;
      if (light_out !== 1'b0) begin errors++; $display("FAIL fast_light_clear got %0b want 0", light_out); end
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; mode = 2'b00;
      prof_we = 1'b0; prof_addr = '0; prof_rate = '0; prof_dur = '0;
      test_reset();
      test_walk();
      test_back_to_back();
      test_saturate();
      test_reset_midrun();
      test_mode_ignore();
      test_profile();
      test_zero_profile();
      test_fast();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
